fptd_decode_scheduler: RTL
==========================

Name: fptd_decode_scheduler

Overview:
- Parametrised iteration scheduler and error-statistics engine for the fully-parallel turbo decoder.
- Sequences one frame decode: clear, termination load, N iterations in odd-even or flooding schedule, optional early stop on hard-decision stability, then final error capture.
- Drives the nClear / Enable_Odd / Enable_Even / Enable_Term / Enable_Error_Counter inputs of the upper and lower decoder arrays.
- Accumulates bit and frame error totals across frames for BER/FER measurement.

Parameters:
- FL, 104, frame length in bits (width of Hard_Dec and b1_error).
- ITW, 6, width of Num_Iter and Iter_Used.
- ECW, 7, width of per-frame Error_Count.
- ACW, 32, width of Total_Bit_Errors and Total_Frame_Errors (saturating).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin frame decode; sampled only in IDLE.
- Num_Iter  in  ITW  iterations to run; 0 treated as 1; sampled on accepted Start.
- Flood_Mode  in  1  0 = odd-even (2 phase cycles/iter), 1 = flooding (1 cycle/iter); sampled on Start.
- Early_Stop_En  in  1  enable stability-based early stop; sampled on Start.
- Stats_Clear  in  1  synchronous clear of the Total_* accumulators.
- Hard_Dec  in  FL  decoder hard decisions (sign bits of be1).
- b1_error  in  FL  per-bit error flags from the decoder sections.
- nClear  out  1  active-low decoder state clear.
- Enable_Odd  out  1  odd-section enable.
- Enable_Even  out  1  even-section enable.
- Enable_Term  out  1  termination-section enable.
- Enable_Error_Counter  out  1  decoder error counter capture enable.
- Busy  out  1  high from accepted Start until Done.
- Done  out  1  one-cycle pulse; results valid.
- Iter_Used  out  ITW  iterations actually executed.
- Error_Count  out  ECW  popcount(b1_error) at end of frame, saturated to 2^ECW-1.
- Early_Stopped  out  1  frame ended by stability stop.
- Total_Bit_Errors  out  ACW  saturating sum of Error_Count.
- Total_Frame_Errors  out  ACW  saturating count of frames with Error_Count != 0.

Behaviour:
- Reset: FSM to IDLE. nClear = 1. All enables, Busy, Done and Early_Stopped = 0. Iter_Used, Error_Count and the totals = 0.
- Reset mid-frame aborts the frame immediately with no Done. Reset takes priority over all other inputs.
- All outputs are registered.
- FSM states: IDLE, CLEAR, TERM, ODD, EVEN, CHECK, COUNT, DONE.
- IDLE:
  - Start = 1 → CLEAR. Latch Num_Iter (0 → 1), Flood_Mode and Early_Stop_En.
  - Set iter counter = 0, Busy = 1.
- CLEAR: nClear = 0 for exactly 1 cycle → TERM.
- TERM: Enable_Term = 1 for 1 cycle → ODD.
- ODD:
  - Enable_Odd = 1. If flooding, Enable_Even = 1 in the same cycle → CHECK.
  - Otherwise → EVEN.
- EVEN: Enable_Even = 1 → CHECK.
- CHECK: no enables. Increment iter counter, then:
  - If iter counter (after increment) == latched Num_Iter → COUNT.
  - Else if Early_Stop_En and iter counter ≥ 2 and Hard_Dec == previous snapshot → COUNT with Early_Stopped = 1.
  - Else → ODD.
  - Snapshot register <= Hard_Dec every CHECK.
- Iteration-count limit has priority over early stop. If both hold, Early_Stopped = 0.
- COUNT:
  - Enable_Error_Counter = 1.
  - Error_Count <= min(popcount(b1_error), 2^ECW-1).
  - Iter_Used <= iter counter.
  - → DONE.
- DONE:
  - Done = 1 for 1 cycle.
  - Totals update: Total_Bit_Errors += Error_Count; Total_Frame_Errors += (Error_Count != 0). Both saturate at 2^ACW-1.
  - Busy = 0 next cycle → IDLE.
- Start while not in IDLE is ignored; it is not queued.
- Frame latency from Start to Done: 3 + K·(cycles/iter) + 2 clocks, where cycles/iter = 3 (odd-even) or 2 (flooding) and K = Iter_Used.
- Stats_Clear zeroes both totals. If it coincides with DONE, the clear wins and that frame is not added.
- Iter_Used, Error_Count and Early_Stopped hold their values until the next COUNT/DONE.
- Exactly one of the phase enables (or Odd+Even together in flooding) is high per cycle. Enable_Term never overlaps Enable_Odd or Enable_Even.

Test Plan:
- Reset then Start, Num_Iter=4, odd-even, no early stop → Done 17 cycles after Start; Enable_Odd pulses 4, Enable_Even pulses 4, Iter_Used=4, Busy high throughout.
- Same with Flood_Mode=1 → Done 13 cycles after Start; Odd and Even asserted together 4 times.
- Early_Stop_En=1, Num_Iter=8, Hard_Dec held constant → stop at CHECK of iteration 2; Iter_Used=2, Early_Stopped=1.
- Num_Iter=0 → runs 1 iteration, Iter_Used=1.
- FL=8, b1_error=8'b1011_0001 over 3 frames → Error_Count=4 each; Total_Bit_Errors=12, Total_Frame_Errors=3.
- ACW=4 saturation: totals stop at 15. Stats_Clear coincident with DONE leaves totals 0. Reset asserted in EVEN → no Done, nClear=1, Busy=0 next cycle. Start pulsed while Busy is ignored.

Source files
------------

// File: rtl/fptd_decode_scheduler_if.sv
// ---------------------------------------------------------------------------
// fptd_decode_scheduler_if
//   Bundles the control, decoder-status and statistics signals of the turbo
//   decoder iteration scheduler.
//
//   master : frame controller / host side (drives Start and the frame
//            configuration, supplies the decoder hard decisions and error
//            flags, observes enables, status and totals).
//   slave  : the scheduler itself.
//
//   Signals
//     Start, Num_Iter, Flood_Mode, Early_Stop_En   frame request + config
//     Stats_Clear                                 clear BER/FER totals
//     Hard_Dec, b1_error                          decoder array status
//     nClear, Enable_*                            decoder array controls
//     Busy, Done, Iter_Used, Error_Count,
//     Early_Stopped                               per-frame result
//     Total_Bit_Errors, Total_Frame_Errors        saturating totals
// ---------------------------------------------------------------------------
interface fptd_decode_scheduler_if #(
    parameter int FL  = 104,
    parameter int ITW = 6,
    parameter int ECW = 7,
    parameter int ACW = 32
);
    logic           Start;
    logic [ITW-1:0] Num_Iter;
    logic           Flood_Mode;
    logic           Early_Stop_En;
    logic           Stats_Clear;
    logic [FL-1:0]  Hard_Dec;
    logic [FL-1:0]  b1_error;

    logic           nClear;
    logic           Enable_Odd;
    logic           Enable_Even;
    logic           Enable_Term;
    logic           Enable_Error_Counter;
    logic           Busy;
    logic           Done;
    logic [ITW-1:0] Iter_Used;
    logic [ECW-1:0] Error_Count;
    logic           Early_Stopped;
    logic [ACW-1:0] Total_Bit_Errors;
    logic [ACW-1:0] Total_Frame_Errors;

    modport master (
        output Start, Num_Iter, Flood_Mode, Early_Stop_En, Stats_Clear,
               Hard_Dec, b1_error,
        input  nClear, Enable_Odd, Enable_Even, Enable_Term,
               Enable_Error_Counter, Busy, Done, Iter_Used, Error_Count,
               Early_Stopped, Total_Bit_Errors, Total_Frame_Errors
    );

    modport slave (
        input  Start, Num_Iter, Flood_Mode, Early_Stop_En, Stats_Clear,
               Hard_Dec, b1_error,
        output nClear, Enable_Odd, Enable_Even, Enable_Term,
               Enable_Error_Counter, Busy, Done, Iter_Used, Error_Count,
               Early_Stopped, Total_Bit_Errors, Total_Frame_Errors
    );
endinterface

// File: rtl/fptd_decode_scheduler.sv
// ---------------------------------------------------------------------------
// fptd_decode_scheduler
//   Iteration scheduler and error-statistics engine for the fully-parallel
//   turbo decoder. One accepted Start runs a frame:
//     CLEAR (nClear low) -> TERM -> { ODD [-> EVEN] -> CHECK } x K
//     -> COUNT (capture error count) -> DONE (pulse, update totals)
//   K is the latched iteration count, or fewer when early stop finds the
//   hard decisions unchanged between two consecutive iterations.
//
//   Ports
//     Clock  : rising-edge clock
//     Reset  : synchronous, active-high; aborts any frame without Done
//     bus    : fptd_decode_scheduler_if.slave (request, decoder controls,
//              per-frame results, saturating BER/FER totals)
//   Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module fptd_decode_scheduler #(
    parameter int FL  = 104,
    parameter int ITW = 6,
    parameter int ECW = 7,
    parameter int ACW = 32
) (
    input  logic                        Clock,
    input  logic                        Reset,
    fptd_decode_scheduler_if.slave      bus
);
    localparam int PCW = $clog2(FL + 1);
    // common width for comparing the raw popcount with the Error_Count ceiling
    localparam int CW  = (PCW > ECW) ? PCW : ECW;
    // one extra bit so the bit-error sum can be checked for overflow
    localparam int SW  = ((ACW > ECW) ? ACW : ECW) + 1;

    localparam logic [ECW-1:0] EC_MAX = '1;
    localparam logic [ACW-1:0] AC_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, TERM, ODD, EVEN, CHECK, COUNT, DONE
    } state_t;

    state_t         state;
    logic [ITW-1:0] num_iter_q;
    logic [ITW-1:0] iter_cnt;
    logic           flood_q;
    logic           es_en_q;
    logic           es_q;       // frame is ending on a stability stop
    logic [FL-1:0]  snap_q;     // hard decisions seen at the previous CHECK

    logic [ITW-1:0] iter_nxt;
    logic           iter_done;
    logic           es_hit;
    logic [PCW-1:0] pop;
    logic [CW-1:0]  pop_w;
    logic [ECW-1:0] err_sat;
    logic [SW-1:0]  bit_sum;
    logic [ACW-1:0] bit_nxt;
    logic [ACW-1:0] frm_nxt;

    // -----------------------------------------------------------------------
    // Iteration bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        iter_nxt  = iter_cnt + ITW'(1);
        iter_done = (iter_nxt == num_iter_q);
        // stability can only be judged once two iterations have produced
        // decisions, i.e. the snapshot holds a value from this frame
        es_hit    = es_en_q && (iter_nxt >= ITW'(2)) && (bus.Hard_Dec == snap_q);
    end

    // -----------------------------------------------------------------------
    // Per-frame error count: popcount of b1_error clipped to ECW bits
    // -----------------------------------------------------------------------
    always_comb begin
        pop = '0;
        for (int i = 0; i < FL; i++) begin
            pop = pop + PCW'(bus.b1_error[i]);
        end
        pop_w = CW'(pop);
        if (pop_w > CW'(EC_MAX)) begin
            err_sat = EC_MAX;
        end else begin
            err_sat = ECW'(pop_w);
        end
    end

    // -----------------------------------------------------------------------
    // Saturating accumulators, fed from the registered Error_Count
    // -----------------------------------------------------------------------
    always_comb begin
        bit_sum = SW'(bus.Total_Bit_Errors) + SW'(bus.Error_Count);
        if (bit_sum > SW'(AC_MAX)) begin
            bit_nxt = AC_MAX;
        end else begin
            bit_nxt = ACW'(bit_sum);
        end

        if ((bus.Error_Count == '0) || (bus.Total_Frame_Errors == AC_MAX)) begin
            frm_nxt = bus.Total_Frame_Errors;
        end else begin
            frm_nxt = bus.Total_Frame_Errors + ACW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Scheduler FSM. Enables are set on the edge that enters the state they
    // belong to, so each is high exactly while the FSM sits in that state.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state                    <= IDLE;
            num_iter_q               <= '0;
            iter_cnt                 <= '0;
            flood_q                  <= 1'b0;
            es_en_q                  <= 1'b0;
            es_q                     <= 1'b0;
            snap_q                   <= '0;
            bus.nClear               <= 1'b1;
            bus.Enable_Odd           <= 1'b0;
            bus.Enable_Even          <= 1'b0;
            bus.Enable_Term          <= 1'b0;
            bus.Enable_Error_Counter <= 1'b0;
            bus.Busy                 <= 1'b0;
            bus.Done                 <= 1'b0;
            bus.Iter_Used            <= '0;
            bus.Error_Count          <= '0;
            bus.Early_Stopped        <= 1'b0;
            bus.Total_Bit_Errors     <= '0;
            bus.Total_Frame_Errors   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        num_iter_q <= (bus.Num_Iter == '0) ? ITW'(1) : bus.Num_Iter;
                        flood_q    <= bus.Flood_Mode;
                        es_en_q    <= bus.Early_Stop_En;
                        iter_cnt   <= '0;
                        es_q       <= 1'b0;
                        bus.Busy   <= 1'b1;
                        bus.nClear <= 1'b0;
                        state      <= CLEAR;
                    end
                end

                CLEAR: begin
                    bus.nClear      <= 1'b1;
                    bus.Enable_Term <= 1'b1;
                    state           <= TERM;
                end

                TERM: begin
                    bus.Enable_Term <= 1'b0;
                    bus.Enable_Odd  <= 1'b1;
                    // flooding fires both halves in the same cycle
                    bus.Enable_Even <= flood_q;
                    state           <= ODD;
                end

                ODD: begin
                    bus.Enable_Odd <= 1'b0;
                    if (flood_q) begin
                        bus.Enable_Even <= 1'b0;
                        state           <= CHECK;
                    end else begin
                        bus.Enable_Even <= 1'b1;
                        state           <= EVEN;
                    end
                end

                EVEN: begin
                    bus.Enable_Even <= 1'b0;
                    state           <= CHECK;
                end

                CHECK: begin
                    iter_cnt <= iter_nxt;
                    snap_q   <= bus.Hard_Dec;
                    // the iteration limit wins over early stop
                    if (iter_done) begin
                        bus.Enable_Error_Counter <= 1'b1;
                        state                    <= COUNT;
                    end else if (es_hit) begin
                        es_q                     <= 1'b1;
                        bus.Enable_Error_Counter <= 1'b1;
                        state                    <= COUNT;
                    end else begin
                        bus.Enable_Odd  <= 1'b1;
                        bus.Enable_Even <= flood_q;
                        state           <= ODD;
                    end
                end

                COUNT: begin
                    bus.Enable_Error_Counter <= 1'b0;
                    bus.Error_Count          <= err_sat;
                    bus.Iter_Used            <= iter_cnt;
                    bus.Early_Stopped        <= es_q;
                    bus.Done                 <= 1'b1;
                    state                    <= DONE;
                end

                DONE: begin
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase

            // a clear arriving in DONE discards that frame's contribution
            if (bus.Stats_Clear) begin
                bus.Total_Bit_Errors   <= '0;
                bus.Total_Frame_Errors <= '0;
            end else if (state == DONE) begin
                bus.Total_Bit_Errors   <= bit_nxt;
                bus.Total_Frame_Errors <= frm_nxt;
            end
        end
    end

endmodule
